tick_gen_multi: RTL and testbench

Multi-channel programmable tick generator for slow control, display shifting and timeout pacing. It is the parametrised successor of the fixed single-channel 2-second strobe. A shared prescaler feeds NCH independent channels. Each channel has a runtime-loadable period, an enable, periodic or one-shot mode, and either a pulse output, a toggling level output, or both.

---
 rtl/tick_gen_multi.sv | 156 +++++++++++++++
 tb/tb_tick_gen_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tick_gen_multi                                                  |
// | Purpose  : Multi-channel programmable tick generator. A shared prescaler   |
// |            produces a base strobe; NCH independent channels count strobes  |
// |            up to a runtime-loadable period and emit a one-cycle tick, an   |
// |            optional toggling level and, in one-shot mode, a busy flag.     |
// | Ports    : clk, rst           - clock, asynchronous active-high reset      |
// |            cfg_we/cfg_ch      - config write strobe and target channel     |
// |            cfg_period/mode    - new period (base strobes) and mode bits    |
// |                                 (bit0 one-shot, bit1 level toggle enable)  |
// |            ch_en, start       - per-channel run enable / one-shot arm      |
// |            tick, level, busy  - per-channel outputs                        |
// |            cfg_err            - one-cycle pulse on a rejected config write |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tick_gen_multi #(
    parameter int NCH            = 4,
    parameter int CW             = 27,
    parameter int PRESCALE       = 1,
    parameter int DEFAULT_PERIOD = 100_000_000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [CW-1:0]                          cfg_period,
    input  logic [1:0]                             cfg_mode,
    input  logic [NCH-1:0]                         ch_en,
    input  logic [NCH-1:0]                         start,
    output logic [NCH-1:0]                         tick,
    output logic [NCH-1:0]                         level,
    output logic [NCH-1:0]                         busy,
    output logic                                   cfg_err
);

    localparam int            c_PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] c_DEF_PERIOD = CW'(DEFAULT_PERIOD);
    localparam logic [CW-1:0] c_ONE        = CW'(1);

    logic w_strobe;
    logic w_cfg_ch_ok;
    logic w_cfg_ok;
    logic r_cfg_err;

    // ------------------------------------------------------------------
    // Base strobe. With PRESCALE=1 there is nothing to count, so the
    // strobe is simply held high and no prescaler flops exist.
    // ------------------------------------------------------------------
    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);
            logic [c_PW-1:0] r_pre;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pre <= '0;
                end else if (r_pre == c_PRE_LAST) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + c_PW'(1);
                end
            end

            assign w_strobe = (r_pre == c_PRE_LAST);
        end else begin : g_no_prescale
            assign w_strobe = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Config write qualification. The channel range test matters only
    // when NCH is not a power of two (otherwise every code is valid).
    // ------------------------------------------------------------------
    assign w_cfg_ch_ok = (32'(cfg_ch) < 32'(NCH));
    assign w_cfg_ok    = cfg_we && (cfg_period != '0) && w_cfg_ch_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
        end
    end

    assign cfg_err = r_cfg_err;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] r_period;
            logic [CW-1:0] r_cnt;
            logic [1:0]    r_mode;
            logic          r_tick;
            logic          r_level;
            logic          r_busy;
            logic          w_sel;
            logic          w_arm;
            logic          w_running;

            assign w_sel     = w_cfg_ok && (32'(cfg_ch) == 32'(gi));
            // A start is only meaningful for an enabled, idle one-shot.
            assign w_arm     = ch_en[gi] && r_mode[0] && !r_busy && start[gi];
            assign w_running = ch_en[gi] && (!r_mode[0] || r_busy);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_period <= c_DEF_PERIOD;
                    r_mode   <= 2'b00;
                    r_cnt    <= '0;
                    r_tick   <= 1'b0;
                    r_level  <= 1'b0;
                    r_busy   <= 1'b0;
                end else begin
                    r_tick <= 1'b0;
                    // Priority: config write, then disable, then arm, then count.
                    // A config write also suppresses an expiry in the same cycle.
                    if (w_sel) begin
                        r_period <= cfg_period;
                        r_mode   <= cfg_mode;
                        r_cnt    <= '0;
                        r_busy   <= 1'b0;
                    end else if (!ch_en[gi]) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b0;
                    end else if (w_arm) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                    end else if (w_running && w_strobe) begin
                        if (r_cnt == r_period - c_ONE) begin
                            r_cnt  <= '0;
                            r_tick <= 1'b1;
                            if (r_mode[1]) begin
                                r_level <= ~r_level;
                            end
                            // One-shot drops busy on the same edge the tick rises.
                            if (r_mode[0]) begin
                                r_busy <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
            end

            assign tick[gi]  = r_tick;
            assign level[gi] = r_level;
            assign busy[gi]  = r_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tick_gen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tick_gen_multi                                               |
// | Purpose  : Scoreboard bench for tick_gen_multi. Two instances share one    |
// |            stimulus stream: one with PRESCALE=1/period 5, one with         |
// |            PRESCALE=3/period 2. A reference model predicts each cycle's    |
// |            outputs into a queue; a monitor pops and compares at negedge.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tick_gen_multi;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int CHW  = 2;
    localparam int PS_A = 1;
    localparam int DP_A = 5;
    localparam int PS_B = 3;
    localparam int DP_B = 2;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] level;
        logic [NCH-1:0] busy;
        logic           err;
    } obs_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_period = '0;
    logic [1:0]     cfg_mode = 2'b00;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] start = '0;

    logic [NCH-1:0] tick_a, level_a, busy_a;
    logic [NCH-1:0] tick_b, level_b, busy_b;
    logic           err_a, err_b;

    int n_tests = 0;
    int n_fail  = 0;

    obs_t q_a[$];
    obs_t q_b[$];

    always #5 clk = ~clk;

    tick_gen_multi #(.NCH(NCH), .CW(CW), .PRESCALE(PS_A), .DEFAULT_PERIOD(DP_A)) dut_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_mode(cfg_mode), .ch_en(ch_en), .start(start),
        .tick(tick_a), .level(level_a), .busy(busy_a), .cfg_err(err_a)
    );

    tick_gen_multi #(.NCH(NCH), .CW(CW), .PRESCALE(PS_B), .DEFAULT_PERIOD(DP_B)) dut_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_mode(cfg_mode), .ch_en(ch_en), .start(start),
        .tick(tick_b), .level(level_b), .busy(busy_b), .cfg_err(err_b)
    );

    // ------------------------------------------------------------------
    // Reference model: per channel, count strobes accumulated since the
    // channel was last cleared/armed; periodic ticks fall on multiples of
    // the period, a one-shot ticks once when the count reaches the period.
    // The strobe is every PRESCALE-th edge since reset release.
    // ------------------------------------------------------------------
    int       m_edge   [2];
    int       m_period [2][NCH];
    int       m_acc    [2][NCH];
    bit [1:0] m_mode   [2][NCH];
    bit       m_busy   [2][NCH];
    bit       m_level  [2][NCH];

    task automatic model_step(input int i, input int ps, input int dp, output obs_t e);
        bit strobe;
        bit rej;
        e = '0;
        if (rst) begin
            m_edge[i] = 0;
            for (int c = 0; c < NCH; c++) begin
                m_period[i][c] = dp;
                m_acc[i][c]    = 0;
                m_mode[i][c]   = 2'b00;
                m_busy[i][c]   = 1'b0;
                m_level[i][c]  = 1'b0;
            end
            return;
        end
        strobe    = ((m_edge[i] % ps) == ps - 1);
        m_edge[i] = m_edge[i] + 1;
        rej       = cfg_we && ((cfg_period == '0) || (int'(cfg_ch) >= NCH));
        e.err     = rej;
        for (int c = 0; c < NCH; c++) begin
            if (cfg_we && !rej && int'(cfg_ch) == c) begin
                m_period[i][c] = int'(cfg_period);
                m_mode[i][c]   = cfg_mode;
                m_acc[i][c]    = 0;
                m_busy[i][c]   = 1'b0;
            end else if (!ch_en[c]) begin
                m_acc[i][c]  = 0;
                m_busy[i][c] = 1'b0;
            end else if (m_mode[i][c][0] && !m_busy[i][c] && start[c]) begin
                m_busy[i][c] = 1'b1;
                m_acc[i][c]  = 0;
            end else if (strobe && (!m_mode[i][c][0] || m_busy[i][c])) begin
                m_acc[i][c] = m_acc[i][c] + 1;
                if (m_mode[i][c][0]) begin
                    if (m_acc[i][c] == m_period[i][c]) begin
                        e.tick[c]    = 1'b1;
                        m_busy[i][c] = 1'b0;
                    end
                end else if ((m_acc[i][c] % m_period[i][c]) == 0) begin
                    e.tick[c] = 1'b1;
                end
                if (e.tick[c] && m_mode[i][c][1]) begin
                    m_level[i][c] = ~m_level[i][c];
                end
            end
            e.level[c] = m_level[i][c];
            e.busy[c]  = m_busy[i][c];
        end
    endtask

    always @(posedge clk) begin : p_model
        obs_t ea;
        obs_t eb;
        model_step(0, PS_A, DP_A, ea);
        model_step(1, PS_B, DP_B, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
    end

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_tests = n_tests + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s t=%0t: got tick=%b level=%b busy=%b err=%b, expected tick=%b level=%b busy=%b err=%b",
                     name, $time, got.tick, got.level, got.busy, got.err,
                     want.tick, want.level, want.busy, want.err);
        end
    endtask

    // Monitor: one prediction per edge, consumed at the following negedge.
    always @(negedge clk) begin : p_monitor
        obs_t want;
        if (q_a.size() > 0) begin
            want = q_a.pop_front();
            if (!rst) check("dut_a", {tick_a, level_a, busy_a, err_a}, want);
        end
        if (q_b.size() > 0) begin
            want = q_b.pop_front();
            if (!rst) check("dut_b", {tick_b, level_b, busy_b, err_b}, want);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int ch, input int per, input logic [1:0] mode);
        cfg_we     = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_period = CW'(per);
        cfg_mode   = mode;
        step();
        cfg_we     = 1'b0;
    endtask

    initial begin : p_stim
        int k;
        step(3);
        rst = 1'b0;

        // Channel 0 periodic at the default period.
        ch_en = 4'b0001;
        step(20);

        // Channel 1: period 3 with level toggle.
        cfg(1, 3, 2'b10);
        ch_en = 4'b0011;
        step(20);

        // Channel 2: one-shot period 4, second start while busy is ignored.
        cfg(2, 4, 2'b01);
        ch_en = 4'b0111;
        step();
        start = 4'b0100;
        step();
        start = 4'b0000;
        step();
        start = 4'b0100;
        step();
        start = 4'b0000;
        step(20);

        // Rejected writes: zero period.
        cfg(0, 0, 2'b00);
        step(3);
        cfg(3, 0, 2'b11);
        step(10);

        // Drop and re-raise ch0 mid-count.
        step(2);
        ch_en[0] = 1'b0;
        step(2);
        ch_en[0] = 1'b1;
        step(15);

        // Async reset with dut_a ch0 at count 4 of 5.
        k = 0;
        while (k < 20 && !tick_a[0]) begin
            step();
            k++;
        end
        if (!tick_a[0]) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL wait_tick0: got no tick within 20 cycles, expected a tick");
        end
        step(4);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_a", {tick_a, level_a, busy_a, err_a}, '0);
        check("rst_async_b", {tick_b, level_b, busy_b, err_b}, '0);
        step(2);
        rst = 1'b0;
        step(30);

        // Randomised traffic, including config and start in the same cycle.
        ch_en = 4'b1111;
        for (int n = 0; n < 400; n++) begin
            start = NCH'($urandom_range(0, 15)) & NCH'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                ch_en = ch_en ^ NCH'(1 << $urandom_range(0, NCH - 1));
            end
            if ($urandom_range(0, 99) < 8) begin
                cfg($urandom_range(0, NCH - 1),
                    ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6),
                    2'($urandom_range(0, 3)));
            end else begin
                step();
            end
            start = '0;
        end

        ch_en = '0;
        step(3);
        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
